// File: rtl/tiler_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tiler_addr_gen_pkg
// Brief    : Shared constants, instruction layout and FSM state encoding for
//            the tiler address generator.
// Revision : 1.0  initial release
// ============================================================================
package tiler_addr_gen_pkg;

    localparam int DRAM_DEPTH    = 1024;
    localparam int ADDR_WIDTH    = $clog2(DRAM_DEPTH);
    localparam int TOTAL_DIGITS  = 9;

    // Word indices inside one instruction
    localparam int SIZE_BASE     = 0;
    localparam int STRIDE_BASE   = TOTAL_DIGITS;
    localparam int BASE_IDX      = 2 * TOTAL_DIGITS;
    localparam int INSTRUC_WORDS = 2 * TOTAL_DIGITS + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef addr_t [INSTRUC_WORDS-1:0] instruc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tiler_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : tiler_addr_gen_if
// Brief    : Instruction and address-stream handshake bundle.
// Revision : 1.0  initial release
// ============================================================================
interface tiler_addr_gen_if #(
    parameter int ADDR_WIDTH   = tiler_addr_gen_pkg::ADDR_WIDTH,
    parameter int TOTAL_DIGITS = tiler_addr_gen_pkg::TOTAL_DIGITS
) ();

    logic                                   instruc_valid;
    logic                                   instruc_ready;
    logic [2*TOTAL_DIGITS:0][ADDR_WIDTH-1:0] instruc;
    logic                                   addr_valid;
    logic                                   addr_ready;
    logic [ADDR_WIDTH-1:0]                  addr;
    logic                                   addr_last;
    logic [TOTAL_DIGITS-1:0]                digit_last;
    logic                                   busy;

    modport slave (
        input  instruc_valid,
        input  instruc,
        input  addr_ready,
        output instruc_ready,
        output addr_valid,
        output addr,
        output addr_last,
        output digit_last,
        output busy
    );

    modport master (
        output instruc_valid,
        output instruc,
        output addr_ready,
        input  instruc_ready,
        input  addr_valid,
        input  addr,
        input  addr_last,
        input  digit_last,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/tiler_addr_gen_digit_chain.sv
`default_nettype none
// ============================================================================
// Module   : tiler_digit_chain
// Brief    : Per-digit loop counters with latched sizes; flags last digits and
//            selects the lowest digit that can still advance.
// Revision : 1.0  initial release
// ============================================================================
module tiler_digit_chain #(
    parameter int ADDR_WIDTH   = tiler_addr_gen_pkg::ADDR_WIDTH,
    parameter int TOTAL_DIGITS = tiler_addr_gen_pkg::TOTAL_DIGITS
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   load,
    input  logic [TOTAL_DIGITS-1:0][ADDR_WIDTH-1:0] sizes_in,
    input  logic                                   step,
    output logic [TOTAL_DIGITS-1:0][ADDR_WIDTH-1:0] sizes,
    output logic [TOTAL_DIGITS-1:0]                digit_last,
    output logic [TOTAL_DIGITS-1:0]                step_onehot,
    output logic                                   all_last
);

    logic [TOTAL_DIGITS-1:0] w_clear_mask;

    // Adding one to the last-flags ripples through the trailing set bits and
    // lands on the lowest clear one; masking isolates that bit.
    assign step_onehot  = ~digit_last & (digit_last + TOTAL_DIGITS'(1));
    assign w_clear_mask = step_onehot - TOTAL_DIGITS'(1);
    assign all_last     = &digit_last;

    generate
        for (genvar i = 0; i < TOTAL_DIGITS; i++) begin : g_digit
            logic [ADDR_WIDTH-1:0] r_count;
            logic [ADDR_WIDTH-1:0] r_size;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                    r_size  <= ADDR_WIDTH'(1);
                end else if (load) begin
                    r_count <= '0;
                    r_size  <= (sizes_in[i] == '0) ? ADDR_WIDTH'(1) : sizes_in[i];
                end else if (step) begin
                    if (step_onehot[i]) begin
                        r_count <= r_count + ADDR_WIDTH'(1);
                    end else if (w_clear_mask[i]) begin
                        r_count <= '0;
                    end
                end
            end

            assign sizes[i]      = r_size;
            assign digit_last[i] = (r_count == (r_size - ADDR_WIDTH'(1)));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tiler_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tiler_addr_gen
// Brief    : Nested-loop address generator: precomputes per-digit rewinds with
//            one shared multiplier, then streams one address per fire.
// Revision : 1.0  initial release
// ============================================================================
module tiler_addr_gen #(
    parameter int ADDR_WIDTH   = tiler_addr_gen_pkg::ADDR_WIDTH,
    parameter int TOTAL_DIGITS = tiler_addr_gen_pkg::TOTAL_DIGITS
) (
    input  logic             clk,
    input  logic             reset,
    tiler_addr_gen_if.slave  bus
);

    import tiler_addr_gen_pkg::*;

    localparam int IDX_W      = $clog2(TOTAL_DIGITS);
    localparam int SIZE_OFS   = 0;
    localparam int STRIDE_OFS = TOTAL_DIGITS;
    localparam int BASE_OFS   = 2 * TOTAL_DIGITS;

    state_t                                 r_state;
    state_t                                 w_state_next;
    logic [IDX_W-1:0]                       r_prep_idx;
    logic [TOTAL_DIGITS-1:0][ADDR_WIDTH-1:0] r_stride;
    logic [TOTAL_DIGITS-1:0][ADDR_WIDTH-1:0] r_rewind;
    logic [ADDR_WIDTH-1:0]                  r_acc;
    logic [ADDR_WIDTH-1:0]                  r_addr;

    logic                                   w_accept;
    logic                                   w_step;
    logic                                   w_fire;
    logic                                   w_prep_done;
    logic [TOTAL_DIGITS-1:0][ADDR_WIDTH-1:0] w_sizes_in;
    logic [TOTAL_DIGITS-1:0][ADDR_WIDTH-1:0] w_sizes;
    logic [TOTAL_DIGITS-1:0]                w_digit_last;
    logic [TOTAL_DIGITS-1:0]                w_step_onehot;
    logic                                   w_all_last;
    logic [ADDR_WIDTH-1:0]                  w_size_m1;
    logic [ADDR_WIDTH-1:0]                  w_stride_cur;
    logic [ADDR_WIDTH-1:0]                  w_prod;
    logic [ADDR_WIDTH-1:0]                  w_step_rewind;

    assign w_fire      = (r_state == ST_RUN) && bus.addr_ready;
    assign w_prep_done = (r_prep_idx == IDX_W'(TOTAL_DIGITS - 1));

    always_comb begin
        for (int i = 0; i < TOTAL_DIGITS; i++) begin
            w_sizes_in[i] = bus.instruc[SIZE_OFS + i];
        end
    end

    tiler_digit_chain #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .TOTAL_DIGITS (TOTAL_DIGITS)
    ) u_chain (
        .clk         (clk),
        .reset       (reset),
        .load        (w_accept),
        .sizes_in    (w_sizes_in),
        .step        (w_step),
        .sizes       (w_sizes),
        .digit_last  (w_digit_last),
        .step_onehot (w_step_onehot),
        .all_last    (w_all_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.instruc_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_PREP;
                end
            end
            ST_PREP: begin
                if (w_prep_done) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fire) begin
                    if (w_all_last) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Shared multiplier: one digit's span (size-1)*stride per PREP cycle.
    assign w_size_m1    = w_sizes[r_prep_idx] - ADDR_WIDTH'(1);
    assign w_stride_cur = r_stride[r_prep_idx];
    assign w_prod       = w_size_m1 * w_stride_cur;

    always_comb begin
        w_step_rewind = '0;
        for (int i = 0; i < TOTAL_DIGITS; i++) begin
            if (w_step_onehot[i]) begin
                w_step_rewind = w_step_rewind | r_rewind[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prep_idx <= '0;
            r_stride   <= '0;
            r_rewind   <= '0;
            r_acc      <= '0;
            r_addr     <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < TOTAL_DIGITS; i++) begin
                r_stride[i] <= bus.instruc[STRIDE_OFS + i];
            end
            r_addr     <= bus.instruc[BASE_OFS];
            r_acc      <= '0;
            r_prep_idx <= '0;
        end else if (r_state == ST_PREP) begin
            // Rewind undoes the travel of all lower digits, then takes one step.
            r_rewind[r_prep_idx] <= w_stride_cur - r_acc;
            r_acc                <= r_acc + w_prod;
            r_prep_idx           <= r_prep_idx + IDX_W'(1);
        end else if (w_step) begin
            r_addr <= r_addr + w_step_rewind;
        end
    end

    assign bus.instruc_ready = (r_state == ST_IDLE);
    assign bus.addr_valid    = (r_state == ST_RUN);
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.addr          = r_addr;
    assign bus.digit_last    = w_digit_last;
    assign bus.addr_last     = w_all_last;

endmodule
`default_nettype wire

// File: tb/tb_tiler_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiler_addr_gen
// Brief    : Directed vector bench for the tiler address generator.
// Revision : 1.0  initial release
// ============================================================================
module tb_tiler_addr_gen;

    import tiler_addr_gen_pkg::*;

    typedef struct {
        addr_t      size0;
        addr_t      stride0;
        addr_t      size1;
        addr_t      stride1;
        addr_t      rest;
        addr_t      base;
        int         n;
        int         exp [8];
        logic [7:0] last0;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    tiler_addr_gen_if bus ();

    tiler_addr_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic load_instr(input vec_t v);
        for (int i = 0; i < INSTRUC_WORDS; i++) bus.instruc[i] = '0;
        for (int i = 0; i < TOTAL_DIGITS; i++) bus.instruc[SIZE_BASE + i] = v.rest;
        bus.instruc[SIZE_BASE]       = v.size0;
        bus.instruc[SIZE_BASE + 1]   = v.size1;
        bus.instruc[STRIDE_BASE]     = v.stride0;
        bus.instruc[STRIDE_BASE + 1] = v.stride1;
        bus.instruc[BASE_IDX]        = v.base;
    endtask

    // Offers an instruction and checks the accept-to-first-valid latency.
    task automatic issue(input vec_t v);
        int cyc;
        cyc = 0;
        while (!bus.instruc_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("instruc_ready_before_issue", bus.instruc_ready, 1);
        load_instr(v);
        bus.instruc_valid = 1'b1;
        @(negedge clk);
        bus.instruc_valid = 1'b0;
        cyc = 1;
        while (!bus.addr_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("first_valid_latency", cyc, 10);
    endtask

    task automatic stream(input vec_t v, input int stall_at, input int stall_len);
        bus.addr_ready = 1'b1;
        for (int k = 0; k < v.n; k++) begin
            if (!bus.addr_valid) begin
                check("addr_valid_in_stream", bus.addr_valid, 1);
                return;
            end
            check($sformatf("addr[%0d]", k), 32'(bus.addr), v.exp[k]);
            check($sformatf("digit_last0[%0d]", k), bus.digit_last[0], v.last0[k]);
            check($sformatf("addr_last[%0d]", k), bus.addr_last, (k == v.n - 1) ? 1 : 0);
            if (k == stall_at) begin
                bus.addr_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_addr", 32'(bus.addr), v.exp[k]);
                    check("stall_valid", bus.addr_valid, 1);
                end
                bus.addr_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("done_addr_valid", bus.addr_valid, 0);
        check("done_instruc_ready", bus.instruc_ready, 1);
        check("done_busy", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{size0: 4, stride0: 1, size1: 1, stride1: 0, rest: 1, base: 100, n: 4,
                    exp: '{100, 101, 102, 103, 0, 0, 0, 0}, last0: 8'b0000_1000};
        vecs[1] = '{size0: 3, stride0: 1, size1: 2, stride1: 10, rest: 1, base: 0, n: 6,
                    exp: '{0, 1, 2, 10, 11, 12, 0, 0}, last0: 8'b0010_0100};
        vecs[2] = '{size0: 0, stride0: 5, size1: 0, stride1: 9, rest: 0, base: 7, n: 1,
                    exp: '{7, 0, 0, 0, 0, 0, 0, 0}, last0: 8'b0000_0001};
        vecs[3] = '{size0: 3, stride0: 1, size1: 1, stride1: 0, rest: 1, base: 1023, n: 3,
                    exp: '{1023, 0, 1, 0, 0, 0, 0, 0}, last0: 8'b0000_0100};
        vecs[4] = '{size0: 2, stride0: 5, size1: 2, stride1: 3, rest: 0, base: 50, n: 4,
                    exp: '{50, 55, 53, 58, 0, 0, 0, 0}, last0: 8'b0000_1010};

        bus.instruc_valid = 1'b0;
        bus.addr_ready    = 1'b0;
        load_instr(vecs[0]);
        repeat (2) @(negedge clk);
        check("reset_addr_valid", bus.addr_valid, 0);
        check("reset_addr", 32'(bus.addr), 0);
        check("reset_instruc_ready", bus.instruc_ready, 1);
        check("reset_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            issue(vecs[v]);
            stream(vecs[v], -1, 0);
        end

        // Backpressure held at address 11
        issue(vecs[1]);
        stream(vecs[1], 4, 5);

        // Instruction offered during RUN is ignored; reset mid-run drops it
        issue(vecs[1]);
        bus.addr_ready = 1'b1;
        check("run_addr0", 32'(bus.addr), 0);
        load_instr(vecs[0]);
        bus.instruc_valid = 1'b1;
        check("run_instruc_ready", bus.instruc_ready, 0);
        @(negedge clk);
        bus.instruc_valid = 1'b0;
        check("run_addr1", 32'(bus.addr), 1);
        check("run_busy", bus.busy, 1);
        @(negedge clk);
        check("run_addr2", 32'(bus.addr), 2);
        reset = 1'b1;
        #1;
        check("midrun_reset_valid", bus.addr_valid, 0);
        check("midrun_reset_ready", bus.instruc_ready, 1);
        check("midrun_reset_busy", bus.busy, 0);
        check("midrun_reset_addr", 32'(bus.addr), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(vecs[0]);
        stream(vecs[0], -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tiler_addr_gen.md
# tiler_addr_gen

Nested-loop address generator that sits directly downstream of the `Tiler` instruction definition. It accepts one `Tiler::Instruc` per tile: per-digit sizes, per-digit strides and a base address. It emits the resulting DRAM/layer-IO address stream with a valid/ready handshake, and drives the read or write port of the layer-IO memory and DRAM paths. Digit 0 is the fastest-varying loop.

## Interface
Parameters:
- `ADDR_WIDTH`, default `Tiler::ADDR_WIDTH` (= `$clog2(Dram::DEPTH)`): width of the generated address.
- `TOTAL_DIGITS`, default `Tiler::TOTAL_DIGITS` (9): loop depth.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `instruc_valid`  in  1  instruction offered.
- `instruc_ready`  out  1  high only in IDLE.
- `instruc`  in  `Tiler::Instruc`  [0..8] sizes, [9..17] strides, [18] base.
- `addr_valid`  out  1  `addr` holds a valid address.
- `addr_ready`  in  1  consumer accepts.
- `addr`  out  ADDR_WIDTH  current address.
- `addr_last`  out  1  final address of the instruction.
- `digit_last`  out  TOTAL_DIGITS  bit i set when digit i is at size_i−1 for the current address.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, PREP, RUN.
- IDLE → PREP on `instruc_valid && instruc_ready`.
  - Latch the sizes; size 0 is treated as 1.
  - Latch the strides and base; clear the counts; set `addr`=base.
- PREP runs one digit per cycle, i = 0..8:
  - rewind_i = stride_i − acc
  - acc += (size_i−1)·stride_i
  - acc starts at 0. All arithmetic is unsigned and modulo 2^ADDR_WIDTH.
  - The block has one shared multiplier.
  - After digit 8 the block goes to RUN and `addr_valid`=1.
- RUN, on fire (`addr_valid && addr_ready`):
  - If all digits are at their last value: `addr_valid`←0, go to IDLE.
  - Otherwise let i = the lowest digit not at its last value.
  - count_i += 1; counts j<i ← 0.
  - `addr` += rewind_i, with modulo wrap (0 follows 2^ADDR_WIDTH−1).
- Without fire, `addr`, `addr_last` and `digit_last` hold.
- `digit_last` and `addr_last` are combinational from the registered counts and latched sizes. `addr_last` = &`digit_last`.
- An `instruc_valid` outside IDLE is ignored. The instruction is not captured and the upstream holds it.
- Total addresses emitted = Π size_i.

## Timing
- Reset values: `addr_valid`=0, `addr`=0, counts=0, state=IDLE, `busy`=0, `instruc_ready`=1. `addr_last` and `digit_last` are don't-care while `addr_valid`=0.
- Reset takes effect immediately, mid-PREP or mid-RUN. An in-flight instruction is dropped.
- Latency: instruction accept at cycle T → PREP T+1..T+9 → first `addr_valid` at T+10.
- Throughput in RUN: one address per cycle while `addr_ready`=1.
- The last fire at cycle L puts the block in IDLE at L+1, where `instruc_ready`=1. The earliest next accept is L+1, so there is no back-to-back overlap.
- `addr_valid` never drops without a fire. Outputs are stable under backpressure.

## Structure
- Add to package `Tiler`:
  - Instruction field indices SIZE_BASE=0, STRIDE_BASE=TOTAL_DIGITS, BASE_IDX=2·TOTAL_DIGITS.
  - `localparam ADDR_WIDTH = $clog2(Dram::DEPTH)`.
  - `typedef logic [ADDR_WIDTH-1:0] ADDR`.
  - A state enum.
- One sub-module, `tiler_digit_chain`:
  - Holds the counts and sizes.
  - Produces `digit_last` and the one-hot index of the lowest non-last digit.
  - Clears lower counts on step.
- The top level holds the FSM, the PREP multiplier/accumulator, the rewind registers and the address register.

## Test plan
- size0=4, stride0=1, other sizes 1, base=100 → 100,101,102,103. `addr_last` only on 103. `instruc_ready` high the cycle after.
- size0=3/stride0=1, size1=2/stride1=10, base=0 → 0,1,2,10,11,12. `digit_last[0]` on 2 and 12.
- Same as the previous case with `addr_ready` low for 5 cycles at address 11 → `addr`=11 and `addr_valid`=1 held for all 5 cycles. The stream resumes with no skip or duplicate.
- All sizes 0, base=7 → exactly one address, 7, with `addr_last`=1. First valid 10 cycles after accept.
- base=2^ADDR_WIDTH−1, size0=3, stride0=1 → 2^ADDR_WIDTH−1, 0, 1.
- `reset` pulsed after the 2nd address of a 6-address run → `addr_valid`=0 immediately, `instruc_ready`=1. A new instruction runs cleanly. An `instruc_valid` pulse during RUN is not accepted.
